// File: rtl/serdesphy_tx_pcs_lanes.sv
// Multi-lane TX PCS: FIFO-buffered parallel words serialised LSB-first per lane, with idle fill,
// a PRBS7 test pattern and sticky overflow/underflow flags.
module serdesphy_tx_pcs_lanes #(
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned LANES      = 1,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [DATA_W-1:0] IDLE_WORD = DATA_W'(4'b1010)
) (
  input  logic                         clk_240m_tx,
  input  logic                         rst,
  input  logic                         tx_en,
  input  logic                         tx_prbs_en,
  input  logic                         tx_idle,
  input  logic [DATA_W-1:0]            tx_data,
  input  logic                         tx_valid,
  output logic                         tx_ready,
  input  logic                         err_clr,
  output logic [LANES-1:0]             tx_serial_data,
  output logic                         tx_serial_valid,
  output logic                         tx_fifo_full,
  output logic                         tx_fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]  tx_fifo_level,
  output logic                         tx_overflow,
  output logic                         tx_underflow,
  output logic                         tx_active
);

  localparam int unsigned S     = DATA_W / LANES;
  localparam int unsigned CNT_W = (S > 1) ? $clog2(S) : 1;
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(S - 1);

  typedef enum logic [1:0] {StOff, StIdle, StData, StPrbs} state_e;

  state_e              state_q, load_state;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   sr_q, sr_shift, load_word, prbs_word;
  logic                ser_valid_q, active_q, overflow_q, underflow_q;
  logic [6:0]          prbs_q, lfsr;
  logic                fb;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]    level_q;
  logic                full, empty, boundary, wr_en, pop, ov_evt, un_evt;

  assign full  = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty = (level_q == '0);
  // Before the first word after OFF there is nothing in flight, so that edge is a boundary too.
  assign boundary = (state_q != StOff) && (!ser_valid_q || cnt_q == CntMax);
  assign wr_en    = tx_valid && !full && tx_en;
  assign pop      = tx_en && boundary && !tx_prbs_en && !tx_idle && !empty;
  assign ov_evt   = tx_valid && full;
  assign un_evt   = tx_en && boundary && (state_q == StData) && empty && !tx_prbs_en && !tx_idle;

  always_comb begin
    lfsr      = (state_q == StPrbs) ? prbs_q : 7'h7F;
    fb        = 1'b0;
    prbs_word = '0;
    for (int i = 0; i < int'(DATA_W); i++) begin
      fb           = lfsr[6] ^ lfsr[5];
      prbs_word[i] = fb;
      lfsr         = {lfsr[5:0], fb};
    end
    load_state = StIdle;
    load_word  = IDLE_WORD;
    if (tx_prbs_en) begin
      load_state = StPrbs;
      load_word  = prbs_word;
    end else if (!tx_idle && !empty) begin
      load_state = StData;
      load_word  = mem[rd_ptr_q];
    end
  end

  always_comb begin
    sr_shift       = '0;
    tx_serial_data = '0;
    for (int k = 0; k < int'(LANES); k++) begin
      sr_shift[k*S +: S] = sr_q[k*S +: S] >> 1;
      tx_serial_data[k]  = sr_q[k*S];
    end
  end

  always_ff @(posedge clk_240m_tx) begin
    if (wr_en) mem[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge clk_240m_tx or posedge rst) begin
    if (rst) begin
      state_q     <= StOff;
      cnt_q       <= '0;
      sr_q        <= '0;
      ser_valid_q <= 1'b0;
      active_q    <= 1'b0;
      prbs_q      <= 7'h7F;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      // A fresh error event outranks a clear in the same cycle.
      overflow_q  <= ov_evt | (overflow_q & ~err_clr);
      underflow_q <= un_evt | (underflow_q & ~err_clr);
      if (!tx_en) begin
        state_q     <= StOff;
        cnt_q       <= '0;
        sr_q        <= '0;
        ser_valid_q <= 1'b0;
        active_q    <= 1'b0;
        wr_ptr_q    <= '0;
        rd_ptr_q    <= '0;
        level_q     <= '0;
      end else begin
        if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        level_q <= level_q + LVL_W'(wr_en) - LVL_W'(pop);
        if (state_q == StOff) begin
          state_q <= StIdle;
        end else if (boundary) begin
          state_q     <= load_state;
          sr_q        <= load_word;
          cnt_q       <= '0;
          ser_valid_q <= 1'b1;
          active_q    <= (load_state == StData);
          if (load_state == StPrbs) prbs_q <= lfsr;
        end else begin
          sr_q  <= sr_shift;
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign tx_ready        = !full;
  assign tx_fifo_full    = full;
  assign tx_fifo_empty   = empty;
  assign tx_fifo_level   = level_q;
  assign tx_serial_valid = ser_valid_q;
  assign tx_active       = active_q;
  assign tx_overflow     = overflow_q;
  assign tx_underflow    = underflow_q;

endmodule

// File: tb/tb_serdesphy_tx_pcs_lanes.sv
// Bench for serdesphy_tx_pcs_lanes: directed stimulus queues expected serial bits; monitors on a
// 1-lane and a 2-lane instance pop and compare them as the DUTs shift.
`timescale 1ns/1ps
module tb_serdesphy_tx_pcs_lanes;

  typedef struct packed {
    logic [1:0] ser;
    logic       act;
    logic       on_active;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   a_act_cnt = 0;
  int   a_idx = 0;
  int   b_idx = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       a_en = 0, a_prbs = 0, a_idle = 0, a_valid = 0, a_clr = 0;
  logic [3:0] a_data = '0;
  logic       a_ready, a_sv, a_full, a_empty, a_ov, a_un, a_act;
  logic [0:0] a_ser;
  logic [3:0] a_level;

  logic       b_en = 0, b_prbs = 0, b_idle = 0, b_valid = 0, b_clr = 0;
  logic [7:0] b_data = '0;
  logic       b_ready, b_sv, b_full, b_empty, b_ov, b_un, b_act;
  logic [1:0] b_ser;
  logic [3:0] b_level;

  always #5 clk = ~clk;

  serdesphy_tx_pcs_lanes dut_a (
    .clk_240m_tx(clk), .rst(rst), .tx_en(a_en), .tx_prbs_en(a_prbs), .tx_idle(a_idle),
    .tx_data(a_data), .tx_valid(a_valid), .tx_ready(a_ready), .err_clr(a_clr),
    .tx_serial_data(a_ser), .tx_serial_valid(a_sv), .tx_fifo_full(a_full),
    .tx_fifo_empty(a_empty), .tx_fifo_level(a_level), .tx_overflow(a_ov),
    .tx_underflow(a_un), .tx_active(a_act)
  );

  serdesphy_tx_pcs_lanes #(
    .DATA_W(8), .LANES(2), .FIFO_DEPTH(8), .IDLE_WORD(8'hAA)
  ) dut_b (
    .clk_240m_tx(clk), .rst(rst), .tx_en(b_en), .tx_prbs_en(b_prbs), .tx_idle(b_idle),
    .tx_data(b_data), .tx_valid(b_valid), .tx_ready(b_ready), .err_clr(b_clr),
    .tx_serial_data(b_ser), .tx_serial_valid(b_sv), .tx_fifo_full(b_full),
    .tx_fifo_empty(b_empty), .tx_fifo_level(b_level), .tx_overflow(b_ov),
    .tx_underflow(b_un), .tx_active(b_act)
  );

  // Items flagged on_active wait for a tx_active cycle, others align to the valid stream.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && a_act) a_act_cnt++;
    if (!rst && a_sv && qa.size() > 0 && (!qa[0].on_active || a_act)) begin
      e = qa.pop_front();
      n_cmp++;
      if (a_ser[0] !== e.ser[0] || (!e.on_active && a_act !== e.act)) begin
        n_bad++;
        $display("FAIL a_stream[%0d]: got ser=%b act=%b, want ser=%b act=%b",
                 a_idx, a_ser[0], a_act, e.ser[0], e.act);
      end
      a_idx++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst && b_sv && qb.size() > 0 && (!qb[0].on_active || b_act)) begin
      e = qb.pop_front();
      n_cmp++;
      if (b_ser !== e.ser || (!e.on_active && b_act !== e.act)) begin
        n_bad++;
        $display("FAIL b_stream[%0d]: got ser=%b act=%b, want ser=%b act=%b",
                 b_idx, b_ser, b_act, e.ser, e.act);
      end
      b_idx++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic push_a(input logic [3:0] w, input logic act, input logic on_act);
    for (int i = 0; i < 4; i++) qa.push_back('{ser: {1'b0, w[i]}, act: act, on_active: on_act});
  endtask

  task automatic push_b(input logic [7:0] w, input logic act);
    for (int i = 0; i < 4; i++) qb.push_back('{ser: {w[4+i], w[i]}, act: act, on_active: 1'b0});
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    n_cmp++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_bad++;
      $display("FAIL %s: got %0d/%0d bits left unobserved, want 0/0", name, qa.size(), qb.size());
      qa.delete();
      qb.delete();
    end
  endtask

  initial begin
    tick();
    check("rst_level", int'(a_level), 0);
    check("rst_empty", int'(a_empty), 1);
    check("rst_full", int'(a_full), 0);
    check("rst_ready", int'(a_ready), 1);
    check("rst_valid", int'(a_sv), 0);
    check("rst_ser", int'(a_ser), 0);
    check("rst_flags", int'({a_ov, a_un, a_act}), 0);
    check("rst_b_valid", int'(b_sv), 0);

    // Single word: idle word first, then data, then underflow back to idle
    rst  = 1'b0;
    a_en = 1'b1;
    b_en = 1'b1;
    push_a(4'hA, 1'b0, 1'b0); push_a(4'h5, 1'b1, 1'b0); push_a(4'hA, 1'b0, 1'b0);
    push_b(8'hAA, 1'b0); push_b(8'hC3, 1'b1); push_b(8'hAA, 1'b0);
    tick();
    a_valid = 1'b1; a_data = 4'h5;
    b_valid = 1'b1; b_data = 8'hC3;
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    drain("single_word", 40);
    check("active_cycles", a_act_cnt, 4);
    check("underflow_set", int'(a_un), 1);
    check("b_underflow_set", int'(b_un), 1);
    check("level_after_pop", int'(a_level), 0);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    check("underflow_cleared", int'(a_un), 0);
    b_en = 1'b0;

    // Fill with idle forced, then overflow and err_clr races
    a_idle = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_valid = 1'b1; a_data = 4'(i);
      tick();
    end
    a_data = 4'hF;
    tick();
    a_valid = 1'b0;
    check("full_level", int'(a_level), 8);
    check("full_flag", int'(a_full), 1);
    check("full_ready", int'(a_ready), 0);
    check("overflow_set", int'(a_ov), 1);
    a_valid = 1'b1; a_data = 4'hE; a_clr = 1'b1;
    tick();
    a_valid = 1'b0; a_clr = 1'b0;
    check("overflow_wins_clr", int'(a_ov), 1);
    check("level_held", int'(a_level), 8);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
    check("overflow_cleared", int'(a_ov), 0);

    a_act_cnt = 0;
    for (int i = 1; i <= 8; i++) push_a(4'(i), 1'b1, 1'b1);
    a_idle = 1'b0;
    drain("fifo_order", 80);
    ticks(12);
    check("ninth_dropped", a_act_cnt, 32);
    check("drain_underflow", int'(a_un), 1);
    check("drain_empty", int'(a_empty), 1);
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;

    // PRBS7 from seed, then re-entry after an idle word restarts the sequence
    a_en = 1'b0;
    tick();
    a_prbs = 1'b1;
    a_en = 1'b1;
    push_a(4'b0000, 1'b0, 1'b0); push_a(4'b0100, 1'b0, 1'b0); push_a(4'hA, 1'b0, 1'b0);
    ticks(2);
    ticks(4);
    a_prbs = 1'b0;
    ticks(4);
    a_prbs = 1'b1;
    ticks(4);
    check("prbs_first_done", qa.size(), 0);
    qa.delete();
    push_a(4'b0000, 1'b0, 1'b0); push_a(4'b0100, 1'b0, 1'b0);
    ticks(4);
    a_prbs = 1'b0;
    drain("prbs_reentry", 40);

    // Disable mid-stream with entries queued flushes everything at once
    a_idle = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_valid = 1'b1; a_data = 4'h3;
      tick();
    end
    a_valid = 1'b0;
    ticks(2);
    check("queued_three", int'(a_level), 3);
    a_en = 1'b0;
    tick();
    check("off_valid", int'(a_sv), 0);
    check("off_level", int'(a_level), 0);
    check("off_empty", int'(a_empty), 1);
    check("off_ser_act", int'({a_ser[0], a_act}), 0);

    // Asynchronous reset mid-word, then restart
    a_en = 1'b1;
    a_valid = 1'b1; a_data = 4'h6;
    tick();
    a_valid = 1'b0;
    ticks(6);
    check("stream_running", int'(a_sv), 1);
    #3;
    rst = 1'b1;
    #1;
    check("async_valid", int'(a_sv), 0);
    check("async_level", int'(a_level), 0);
    check("async_ready", int'(a_ready), 1);
    tick();
    rst = 1'b0;
    a_idle = 1'b0;
    push_a(4'hA, 1'b0, 1'b0); push_a(4'hA, 1'b0, 1'b0);
    drain("post_reset_idle", 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
